// File: rtl/maxnet_pkg.sv
// Shared defaults, FSM state encoding and the accumulator-to-activation conversion
// used by the MaxNet controller and its MAC datapath.
package maxnet_pkg;

  localparam int unsigned DEF_N        = 4;
  localparam int unsigned DEF_WIDTH    = 5;
  localparam int unsigned DEF_FRAC     = 3;
  localparam int unsigned DEF_MAX_ITER = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_MAC,
    S_UPDATE,
    S_DONE
  } state_e;

  // Floor shift by frac, saturate to the signed word range, then clamp negatives to 0.
  function automatic logic signed [31:0] sat_relu(input logic signed [31:0] acc,
                                                  input int unsigned       frac,
                                                  input int unsigned       width);
    logic signed [31:0] shifted;
    logic signed [31:0] max_val;
    shifted = acc >>> frac;
    max_val = (32'sd1 <<< (width - 1)) - 32'sd1;
    if (shifted < 32'sd0) begin
      return 32'sd0;
    end
    if (shifted > max_val) begin
      return max_val;
    end
    return shifted;
  endfunction

endpackage

// File: rtl/maxnet_mac.sv
// Time-shared signed multiply-accumulate with clear/enable and a combinational
// conversion of the running sum (including the current product) to an activation.
module maxnet_mac
  import maxnet_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned FRAC  = DEF_FRAC,
  parameter int unsigned ACC_W = 2 * DEF_WIDTH + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_w,
  output logic [WIDTH-1:0] o_conv_c
);

  localparam int unsigned PROD_W = 2 * WIDTH;

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  r_acc;

  assign w_prod   = $signed(i_a) * $signed(i_w);
  assign w_sum    = r_acc + ACC_W'(w_prod);
  assign o_conv_c = WIDTH'(sat_relu(32'(w_sum), FRAC, WIDTH));

  // Clear wins over enable: the last term of a column is consumed via o_conv_c.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_sum;
    end
  end

endmodule

// File: rtl/maxnet_controller.sv
// MaxNet winner-take-all sequencer: loads activations, iterates the network over a
// single MAC unit and reports winner / no-winner / timeout.
module maxnet_controller
  import maxnet_pkg::*;
#(
  parameter int unsigned N        = DEF_N,
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned FRAC     = DEF_FRAC,
  parameter int unsigned MAX_ITER = DEF_MAX_ITER
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [N*WIDTH-1:0]     x_in,
  input  logic [N*N*WIDTH-1:0]   w_in,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(N)-1:0]   winner,
  output logic                   no_winner,
  output logic                   timeout,
  output logic [3:0]             iter_count
);

  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned ACC_W = 2 * WIDTH + IDX_W;
  localparam int unsigned CNT_W = 4;

  state_e             r_state;
  logic [WIDTH-1:0]   r_a      [N];
  logic [WIDTH-1:0]   r_a_next [N];
  logic [IDX_W-1:0]   r_i;
  logic [IDX_W-1:0]   r_j;
  logic [CNT_W-1:0]   r_iter;
  logic               r_busy;
  logic               r_done;
  logic [IDX_W-1:0]   r_winner;
  logic               r_no_winner;
  logic               r_timeout;

  logic [WIDTH-1:0]   w_x [N];
  logic [WIDTH-1:0]   w_w [N*N];
  logic [IDX_W:0]     w_nz_cnt;
  logic [IDX_W-1:0]   w_nz_idx;
  logic               w_mac_clr;
  logic               w_mac_en;
  logic               w_last_i;
  logic [WIDTH-1:0]   w_conv;

  assign busy       = r_busy;
  assign done       = r_done;
  assign winner     = r_winner;
  assign no_winner  = r_no_winner;
  assign timeout    = r_timeout;
  assign iter_count = r_iter;

  // Unpack the flattened memory buses; {i, j} equals i*N+j because N is a power of two.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_x[k] = x_in[k*WIDTH +: WIDTH];
    end
    for (int k = 0; k < N*N; k++) begin
      w_w[k] = w_in[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    w_nz_cnt = '0;
    w_nz_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (r_a[k] != '0) begin
        w_nz_cnt = w_nz_cnt + (IDX_W+1)'(1);
        w_nz_idx = IDX_W'(k);
      end
    end
  end

  assign w_last_i  = (r_i == IDX_W'(N - 1));
  assign w_mac_en  = (r_state == S_MAC);
  assign w_mac_clr = (r_state == S_LOAD) || (w_mac_en && w_last_i);

  maxnet_mac #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_mac_clr),
    .i_en     (w_mac_en),
    .i_a      (r_a[r_i]),
    .i_w      (w_w[{r_i, r_j}]),
    .o_conv_c (w_conv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_i         <= '0;
      r_j         <= '0;
      r_iter      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_winner    <= '0;
      r_no_winner <= 1'b0;
      r_timeout   <= 1'b0;
      for (int k = 0; k < N; k++) begin
        r_a[k]      <= '0;
        r_a_next[k] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_LOAD;
            r_busy      <= 1'b1;
            r_winner    <= '0;
            r_no_winner <= 1'b0;
            r_timeout   <= 1'b0;
            r_iter      <= '0;
          end
        end
        S_LOAD: begin
          for (int k = 0; k < N; k++) begin
            r_a[k] <= w_x[k][WIDTH-1] ? '0 : w_x[k];
          end
          r_i     <= '0;
          r_j     <= '0;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (w_nz_cnt == (IDX_W+1)'(1)) begin
            r_winner <= w_nz_idx;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else if (w_nz_cnt == '0) begin
            r_no_winner <= 1'b1;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end else if (r_iter == CNT_W'(MAX_ITER)) begin
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          // i walks the sources of neuron j; column result lands when i wraps.
          if (w_last_i) begin
            r_a_next[r_j] <= w_conv;
            r_i           <= '0;
            if (r_j == IDX_W'(N - 1)) begin
              r_j     <= '0;
              r_state <= S_UPDATE;
            end else begin
              r_j <= r_j + IDX_W'(1);
            end
          end else begin
            r_i <= r_i + IDX_W'(1);
          end
        end
        S_UPDATE: begin
          for (int k = 0; k < N; k++) begin
            r_a[k] <= r_a_next[k];
          end
          r_iter  <= r_iter + CNT_W'(1);
          r_state <= S_CHECK;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_controller.sv
// Directed, table-driven bench for maxnet_controller (MAX_ITER=15 and MAX_ITER=1 instances).
module tb_maxnet_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start1;
  logic [19:0] x_in;
  logic [79:0] w_in;

  logic       busy0, done0, nw0, to0;
  logic [1:0] win0;
  logic [3:0] it0;
  logic       busy1, done1, nw1, to1;
  logic [1:0] win1;
  logic [3:0] it1;

  logic       sel;
  logic       m_busy, m_done, m_nw, m_to;
  logic [1:0] m_win;
  logic [3:0] m_it;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  maxnet_controller #(.MAX_ITER(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .x_in(x_in), .w_in(w_in),
    .busy(busy0), .done(done0), .winner(win0), .no_winner(nw0),
    .timeout(to0), .iter_count(it0)
  );

  maxnet_controller #(.MAX_ITER(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .x_in(x_in), .w_in(w_in),
    .busy(busy1), .done(done1), .winner(win1), .no_winner(nw1),
    .timeout(to1), .iter_count(it1)
  );

  assign m_busy = sel ? busy1 : busy0;
  assign m_done = sel ? done1 : done0;
  assign m_nw   = sel ? nw1   : nw0;
  assign m_to   = sel ? to1   : to0;
  assign m_win  = sel ? win1  : win0;
  assign m_it   = sel ? it1   : it0;

  typedef struct {
    string       name;
    logic        use1;
    logic [19:0] x;
    logic [79:0] w;
    int          exp_win;
    int          exp_nw;
    int          exp_to;
    int          exp_it;
    int          exp_cyc;
  } vec_t;

  vec_t tv[8];

  function automatic logic [19:0] mkx(input logic [4:0] a0, input logic [4:0] a1,
                                      input logic [4:0] a2, input logic [4:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [79:0] mkw(input logic [4:0] d, input logic [4:0] o);
    logic [79:0] r;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[(i*4+j)*5 +: 5] = (i == j) ? d : o;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run(input vec_t v, input bit mid_start);
    int c;
    sel  = v.use1;
    x_in = v.x;
    w_in = v.w;
    @(negedge clk);
    start0 = ~v.use1;
    start1 = v.use1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    chk({v.name, " busy after start"}, int'(m_busy), 1);
    c = 0;
    while (!m_done && c < 600) begin
      @(posedge clk);
      #1;
      c++;
      if (mid_start && c == 10) start0 = 1'b1;
      if (mid_start && c == 11) start0 = 1'b0;
    end
    chk({v.name, " done latency"}, c, v.exp_cyc);
    chk({v.name, " winner"}, int'(m_win), v.exp_win);
    chk({v.name, " no_winner"}, int'(m_nw), v.exp_nw);
    chk({v.name, " timeout"}, int'(m_to), v.exp_to);
    chk({v.name, " iter_count"}, int'(m_it), v.exp_it);
    @(posedge clk);
    #1;
    chk({v.name, " done pulse width"}, int'(m_done), 0);
    chk({v.name, " busy low after done"}, int'(m_busy), 0);
    chk({v.name, " winner held"}, int'(m_win), v.exp_win);
  endtask

  initial begin
    logic [79:0] w_std;
    w_std = mkw(5'b01000, 5'b11110);
    tv[0] = '{"clear_winner", 1'b0, mkx(5'd4, 5'd3, 5'd2, 5'd1), w_std, 0, 0, 0, 2, 38};
    tv[1] = '{"tie_collapse", 1'b0, mkx(5'd4, 5'd4, 5'd4, 5'd4), w_std, 0, 1, 0, 2, 38};
    tv[2] = '{"trivial", 1'b0, mkx(5'd0, 5'd0, 5'd5, 5'd0), w_std, 2, 0, 0, 0, 2};
    tv[3] = '{"timeout_mi1", 1'b1, mkx(5'd4, 5'd3, 5'd2, 5'd1), w_std, 0, 0, 1, 1, 20};
    tv[4] = '{"saturate", 1'b0, mkx(5'd15, 5'd15, 5'd15, 5'd15), mkw(5'b01111, 5'b00000),
              0, 0, 1, 15, 272};
    tv[5] = '{"neg_relu", 1'b0, mkx(5'b11000, 5'd2, 5'd0, 5'd0), w_std, 1, 0, 0, 0, 2};
    tv[6] = '{"all_zero", 1'b0, mkx(5'd0, 5'd0, 5'd0, 5'd0), w_std, 0, 1, 0, 0, 2};
    tv[7] = '{"win_at_limit", 1'b1, mkx(5'd8, 5'd1, 5'd0, 5'd0), w_std, 0, 0, 0, 1, 20};

    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    sel    = 1'b0;
    x_in   = '0;
    w_in   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", int'(busy0), 0);
    chk("reset done", int'(done0), 0);
    chk("reset outputs", int'({win0, nw0, to0, it0}), 0);
    chk("reset busy mi1", int'(busy1), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) run(tv[k], 1'b0);

    // Reset during the third iteration of a long run.
    sel  = 1'b0;
    x_in = tv[4].x;
    w_in = tv[4].w;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (40) @(posedge clk);
    #3;
    chk("midrun iter before reset", int'(it0), 2);
    rst_n = 1'b0;
    #1;
    chk("midrun reset busy", int'(busy0), 0);
    chk("midrun reset done", int'(done0), 0);
    chk("midrun reset iter_count", int'(it0), 0);
    chk("midrun reset flags", int'({win0, nw0, to0}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(tv[0], 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/maxnet_controller.md
# maxnet_controller

Sequencing controller for the 4-neuron MaxNet winner-take-all network. Loads the input vector and weight matrix from the memory block's flattened outputs. Runs synchronous MaxNet iterations over a single time-shared multiply-accumulate unit. Reports the winning neuron index, or a no-winner/timeout status, to the top level.

## Interface
- `N`, 4: neuron count. Power of two. The weight matrix is N×N.
- `WIDTH`, 5: activation/weight word width. Signed two's complement.
- `FRAC`, 3: fractional bits. 5'b01000 = 1.0; 5'b11110 = -0.25.
- `MAX_ITER`, 15: iteration limit. Range 1..15.
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin a run. Sampled only in IDLE.
- `x_in` input N*WIDTH: input vector. Element k is `x_in[k*WIDTH +: WIDTH]`.
- `w_in` input N*N*WIDTH: weights. Element i*N+j (i→j) is `w_in[(i*N+j)*WIDTH +: WIDTH]`.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse in the DONE state.
- `winner` output log2(N): index of the surviving neuron. Held until the next accepted start.
- `no_winner` output 1: all activations collapsed to 0. Held until the next accepted start.
- `timeout` output 1: MAX_ITER was reached with more than one nonzero activation. Held until the next accepted start.
- `iter_count` output 4: iterations completed in the current or last run.

## Operation
- **Reset values:** state IDLE. All outputs are 0. The activation registers `a[]` and `a_next[]` are 0.
- **States:** IDLE → LOAD → CHECK → {MAC → UPDATE → CHECK}* → DONE → IDLE.
- **IDLE**
  - `start`=1 moves to LOAD.
  - On that transition, clear `winner`, `no_winner`, `timeout` and `iter_count`.
- **LOAD** (1 cycle): `a[k]` ← ReLU(`x_in[k]`). Negative inputs load as 0. `x_in` and `w_in` are sampled from the memory block. `w_in` must stay stable for the whole run.
- **MAC** (N*N cycles)
  - Counters: j is the outer counter and i the inner counter, both 0..N-1.
  - Each cycle: `acc` += `a[i]` * `w[i*N+j]`. The product is 2*WIDTH bits and `acc` is 2*WIDTH+log2(N) bits, both signed.
  - At i=N-1, the completed accumulation is converted and written to `a_next[j]`; `acc` is cleared.
  - Conversion: arithmetic right shift by FRAC (floor), then saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1], then ReLU to [0, 2^(WIDTH-1)-1].
  - `a[]` is not modified during MAC. All neurons use the previous iteration's activations.
- **UPDATE** (1 cycle): `a[]` ← `a_next[]`, and `iter_count`++.
- **CHECK** (1 cycle): count the nonzero entries of `a[]`. Priority order:
  1. Count = 1: set `winner` to that index and go to DONE.
  2. Count = 0: set `no_winner`=1 and go to DONE.
  3. `iter_count` = MAX_ITER: set `timeout`=1 and go to DONE.
  4. Otherwise go to MAC.
- **Boundary behaviour**
  - A single nonzero input finishes with `iter_count`=0.
  - An all-zero input sets `no_winner` with `iter_count`=0.
  - When count = 1 and MAX_ITER are reached together, the result is the winner; `timeout` stays 0.
- **DONE** (1 cycle): `done`=1, then return to IDLE.
- `start` is ignored while `busy`=1.
- `rst_n` asserted mid-run returns the block to IDLE with all reset values at once, with no completion pulse.

## Timing
- Edge E0 is the edge that samples `start`=1 in IDLE.
- Run from E0:
  - LOAD is exited at E1.
  - The first CHECK is exited at E2.
  - Each iteration takes N*N+2 = 18 cycles.
- After k iterations, DONE is entered at edge E(2+18k), and `done` is high for the following cycle.
- `busy` rises after E0 and falls after the DONE cycle.
- `winner`, `no_winner` and `timeout` are valid in the same cycle `done` is high.
- Back-to-back operation: `start` held high is accepted on the first IDLE cycle after DONE.

## Structure
- **Package `maxnet_pkg`**
  - WIDTH, FRAC and N defaults.
  - State enum: IDLE, LOAD, CHECK, MAC, UPDATE, DONE.
  - Function `sat_relu` (shift, saturate, clamp).
- **Sub-module `maxnet_mac`**
  - Signed multiplier and accumulator, with `clr` and `en` inputs.
  - Conversion output.
  - Purely a datapath; the controller owns the counters and the FSM.

## Test plan
- **Clear winner:** X={00100,00011,00010,00001}, standard W (diag 01000, off-diag 11110).
  - After iteration 1, a = {2,1,0,0}. After iteration 2, a = {1,0,0,0}.
  - Expected: `winner`=0, `iter_count`=2, `done` one cycle after E38.
- **Tie collapse:** X all 00100, standard W.
  - After iteration 1, a = {1,1,1,1}; after iteration 2, all zero.
  - Expected: `no_winner`=1, `iter_count`=2.
- **Trivial input:** X={00000,00000,00101,00000}.
  - Expected: `winner`=2, `iter_count`=0, `done` one cycle after E2.
- **Timeout:** MAX_ITER=1, same X as the first scenario.
  - Expected: `timeout`=1, `iter_count`=1, `winner`=0, `no_winner`=0.
- **Saturation and ReLU:**
  - X all 01111, W diag 01111, off-diag 0: each result is 225>>3=28, saturates to 15, and the run ends with `timeout` at MAX_ITER.
  - X={11000,00010,0,0}: a[0] loads as 0, so `winner`=1 with `iter_count`=0.
- **Reset and start handling:**
  - Assert `rst_n`=0 mid-MAC: `busy` and all outputs go to 0 immediately.
  - Pulse `start` while busy: it is ignored, and the run completes unchanged.
